// File: rtl/stack_ctrl.sv
// stack_ctrl: two-requester round-robin push/pop sequencer for an external stack datapath
module stack_ctrl #(
  parameter int DEPTH = 2,
  parameter int DW    = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         a_req,
  input  logic                         a_op,
  input  logic [DW-1:0]                a_data,
  output logic                         a_ack,
  input  logic                         b_req,
  input  logic                         b_op,
  input  logic [DW-1:0]                b_data,
  output logic                         b_ack,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [DW-1:0]                stk_in,
  input  logic [DW-1:0]                stk_out,
  output logic [DW-1:0]                rd_data,
  output logic                         rd_valid,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf,
  input  logic                         err_clr
);
  localparam int AW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t          state_q;
  logic            gnt_b_q, op_q, prio_b_q, push_q, pop_q;
  logic            a_ack_q, b_ack_q, rd_valid_q, err_q, ovf_q, unf_q;
  logic [DW-1:0]   rd_data_q, stk_in_q;
  logic [AW-1:0]   depth_q;
  logic            gnt_b, req_op, push_ok, pop_ok, rej, ovf_d, unf_d;
  logic [DW-1:0]   req_data;
  // Arbitration, legality of the candidate operation and sticky flag next-state
  always_comb begin
    gnt_b    = b_req & (~a_req | prio_b_q);
    req_op   = gnt_b ? b_op : a_op;
    req_data = gnt_b ? b_data : a_data;
    push_ok  = req_op & (depth_q != AW'(DEPTH));
    pop_ok   = ~req_op & (depth_q != '0);
    rej      = (state_q == ISSUE) & ~push_q & ~pop_q;
    ovf_d    = (ovf_q & ~err_clr) | (rej & op_q);
    unf_d    = (unf_q & ~err_clr) | (rej & ~op_q);
  end
  // IDLE grants and latches, ISSUE strobes the stack, DONE acknowledges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_b_q    <= 1'b0;
      op_q       <= 1'b0;
      prio_b_q   <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_data_q  <= '0;
      stk_in_q   <= '0;
      depth_q    <= '0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      case (state_q)
        IDLE: if (a_req | b_req) begin
          gnt_b_q  <= gnt_b;
          prio_b_q <= ~gnt_b;
          op_q     <= req_op;
          push_q   <= push_ok;
          pop_q    <= pop_ok;
          if (push_ok) stk_in_q <= req_data;
          state_q  <= ISSUE;
        end
        ISSUE: begin
          push_q     <= 1'b0;
          pop_q      <= 1'b0;
          if (push_q) depth_q <= depth_q + AW'(1);
          if (pop_q) begin
            depth_q   <= depth_q - AW'(1);
            rd_data_q <= stk_out;
          end
          a_ack_q    <= ~gnt_b_q;
          b_ack_q    <= gnt_b_q;
          rd_valid_q <= pop_q;
          err_q      <= ~push_q & ~pop_q;
          state_q    <= DONE;
        end
        default: begin
          a_ack_q    <= 1'b0;
          b_ack_q    <= 1'b0;
          rd_valid_q <= 1'b0;
          err_q      <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign stk_push = push_q;
  assign stk_pop  = pop_q;
  assign stk_in   = stk_in_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign depth    = depth_q;
  assign full     = depth_q == AW'(DEPTH);
  assign empty    = depth_q == '0;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed checks of stack_ctrl against a transaction-level stack model
module tb_stack_ctrl;
  localparam int DEPTH = 2;
  localparam int DW    = 9;
  localparam int AW    = $clog2(DEPTH+1);
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_req = 0, a_op = 0, b_req = 0, b_op = 0, err_clr = 0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic a_ack, b_ack, stk_push, stk_pop, rd_valid, err, full, empty, ovf, unf;
  logic [DW-1:0] stk_in, stk_out, rd_data;
  logic [AW-1:0] depth;
  int checks = 0, errors = 0;

  stack_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_op(a_op), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_op(b_op), .b_data(b_data), .b_ack(b_ack),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_in(stk_in), .stk_out(stk_out),
    .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
    .depth(depth), .full(full), .empty(empty),
    .ovf(ovf), .unf(unf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stack datapath driven by the controller's strobes
  logic [DW-1:0] mem [DEPTH];
  int sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp <= 0;
    else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_in;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_out = (sp > 0) ? mem[sp-1] : '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: each operation is grant, issue, acknowledge on consecutive cycles
  int m_phase = 0;
  bit m_gb = 0, m_op = 0, m_legal = 0, m_prio_b = 0, m_ovf = 0, m_unf = 0;
  logic [DW-1:0] m_data = '0, m_rd = '0, m_in = '0;
  logic [DW-1:0] m_q[$];

  task automatic m_reset();
    m_phase = 0; m_gb = 0; m_op = 0; m_legal = 0; m_prio_b = 0;
    m_ovf = 0; m_unf = 0; m_rd = '0; m_in = '0;
    m_q.delete();
  endtask

  task automatic m_step();
    if (err_clr) begin m_ovf = 0; m_unf = 0; end
    case (m_phase)
      0: if (a_req || b_req) begin
        m_gb     = b_req && (!a_req || m_prio_b);
        m_prio_b = !m_gb;
        m_op     = m_gb ? b_op : a_op;
        m_data   = m_gb ? b_data : a_data;
        m_legal  = m_op ? (m_q.size() < DEPTH) : (m_q.size() > 0);
        if (m_legal && m_op) m_in = m_data;
        m_phase  = 1;
      end
      1: begin
        if (m_legal) begin
          if (m_op) m_q.push_back(m_data);
          else m_rd = m_q.pop_back();
        end else if (m_op) m_ovf = 1;
        else m_unf = 1;
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  // Compare every cycle against the model, then advance it with the inputs the next edge will see
  always @(negedge clk) begin
    if (!rst_n) m_reset();
    chk("stk_push", stk_push, m_phase == 1 && m_legal && m_op);
    chk("stk_pop",  stk_pop,  m_phase == 1 && m_legal && !m_op);
    chk("a_ack",    a_ack,    m_phase == 2 && !m_gb);
    chk("b_ack",    b_ack,    m_phase == 2 && m_gb);
    chk("rd_valid", rd_valid, m_phase == 2 && m_legal && !m_op);
    chk("err",      err,      m_phase == 2 && !m_legal);
    chk("depth",    depth,    m_q.size());
    chk("full",     full,     m_q.size() == DEPTH);
    chk("empty",    empty,    m_q.size() == 0);
    chk("ovf",      ovf,      m_ovf);
    chk("unf",      unf,      m_unf);
    chk("rd_data",  rd_data,  m_rd);
    chk("stk_in",   stk_in,   m_in);
    if (rst_n) m_step();
  end

  int n, pu, po, pu_cyc;
  logic [DW-1:0] rd, ins;
  bit rv, er;

  task automatic do_op(input bit b, input bit op, input logic [DW-1:0] d);
    bit got = 0;
    if (b) begin b_req = 1; b_op = op; b_data = d; end
    else begin a_req = 1; a_op = op; a_data = d; end
    n = 0; pu = 0; po = 0; pu_cyc = 0; ins = '0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (stk_push) begin pu++; pu_cyc = n; ins = stk_in; end
      if (stk_pop) po++;
      if (b ? b_ack : a_ack) begin
        got = 1; rd = rd_data; rv = rd_valid; er = err;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (b) b_req = 0; else a_req = 0;
  endtask

  int nack, dual, alt_bad, last;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_depth", depth, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_stk_in", stk_in, 0);
    rst_n = 1;
    // single push, then drain it
    do_op(0, 1, 9'h1A5);
    chk("t1_cycles", n, 3);
    chk("t1_push_once", pu, 1);
    chk("t1_push_cycle", pu_cyc, 2);
    chk("t1_stk_in", ins, 9'h1A5);
    chk("t1_depth", depth, 1);
    chk("t1_empty", empty, 0);
    do_op(0, 0, '0);
    chk("t1_pop_rd", rd, 9'h1A5);
    chk("t1_pop_rv", rv, 1);
    // LIFO order across requesters
    do_op(0, 1, 9'h011);
    do_op(1, 1, 9'h022);
    do_op(0, 0, '0);
    chk("t2_rd1", rd, 9'h022);
    chk("t2_rv1", rv, 1);
    chk("t2_err1", er, 0);
    chk("t2_depth", depth, 1);
    do_op(1, 0, '0);
    chk("t2_rd2", rd, 9'h011);
    chk("t2_empty", empty, 1);
    // overflow
    do_op(0, 1, 9'h033);
    do_op(1, 1, 9'h044);
    do_op(0, 1, 9'h055);
    chk("t3_no_strobe", pu, 0);
    chk("t3_err", er, 1);
    chk("t3_ovf", ovf, 1);
    chk("t3_depth", depth, 2);
    chk("t3_full", full, 1);
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    chk("t3_ovf_clr", ovf, 0);
    do_op(1, 0, '0);
    chk("t3_rd1", rd, 9'h044);
    do_op(0, 0, '0);
    chk("t3_rd2", rd, 9'h033);
    // underflow
    do_op(0, 0, '0);
    chk("t4_no_pop", po, 0);
    chk("t4_err", er, 1);
    chk("t4_rv", rv, 0);
    chk("t4_unf", unf, 1);
    chk("t4_rd_hold", rd, 9'h033);
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    chk("t4_unf_clr", unf, 0);
    // contention: both requests held
    a_req = 1; a_op = 1; a_data = 9'h0AA;
    b_req = 1; b_op = 0;
    nack = 0; dual = 0; alt_bad = 0; last = -1;
    repeat (24) begin
      @(negedge clk);
      if (a_ack && b_ack) dual++;
      if (a_ack || b_ack) begin
        if (last == int'(b_ack)) alt_bad++;
        last = int'(b_ack);
        nack++;
      end
    end
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    chk("t5_acks", nack, 8);
    chk("t5_dual", dual, 0);
    chk("t5_alternate", alt_bad, 0);
    repeat (4) @(posedge clk);
    #1;
    // reset during ISSUE of a push
    a_req = 1; a_op = 1; a_data = 9'h155;
    @(negedge clk);
    @(posedge clk); #2;
    chk("t6_in_issue", stk_push, 1);
    rst_n = 0;
    #1;
    chk("t6_push_low", stk_push, 0);
    chk("t6_depth", depth, 0);
    chk("t6_stk_in", stk_in, 0);
    a_req = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_ack", a_ack, 0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 2, the number of entries in the controlled stack.
REQ-002 SHALL provide parameter DW, default 9, the width of the data path.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports a_req, a_op, input, 1 bit each: requester A's request, held until ack; a_op=1 push, a_op=0 pop.
REQ-006 SHALL have port a_data, input, DW bits: requester A's push data.
REQ-007 SHALL have port a_ack, output, 1 bit: one-cycle completion pulse to requester A.
REQ-008 SHALL have ports b_req, b_op (input, 1 bit), b_data (input, DW bits) and b_ack (output, 1 bit), with the same meanings for requester B.
REQ-009 SHALL have ports stk_push, stk_pop, output, 1 bit each: strobes to the stack datapath.
REQ-010 SHALL have port stk_in, output, DW bits: push data to the stack.
REQ-011 SHALL have port stk_out, input, DW bits: current top-of-stack value from the stack.
REQ-012 SHALL have port rd_data, output, DW bits: popped value; rd_valid, output, 1 bit, qualifies it.
REQ-013 SHALL have port err, output, 1 bit: qualifies the current ack as a rejected operation.
REQ-014 SHALL have port depth, output, clog2(DEPTH+1) bits: current occupancy; full and empty, output, 1 bit each.
REQ-015 SHALL have ports ovf and unf, output, 1 bit each: sticky overflow and underflow flags; err_clr, input, 1 bit, clears them.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE and DONE; each accepted operation takes exactly 3 cycles, IDLE->ISSUE->DONE->IDLE.
REQ-017 IDLE: if any req is high, SHALL grant one requester and latch its op/data; grant is registered, so no strobes are driven in IDLE.
REQ-018 Arbitration SHALL be round-robin: if both requests are high, grant the requester not granted last; a single request is granted immediately.
REQ-019 ISSUE, legal push (depth<DEPTH): SHALL assert stk_push=1 and stk_in=latched data for exactly one cycle; depth SHALL increment at the end of the cycle.
REQ-020 ISSUE, legal pop (depth>0): SHALL assert stk_pop=1 for exactly one cycle, capture stk_out into rd_data at the end of the cycle (the pre-pop top), and decrement depth.
REQ-021 stk_push and stk_pop SHALL never be high together and SHALL be 0 in every state except ISSUE.
REQ-022 A push when full SHALL drive no strobe, leave depth unchanged and set ovf.
REQ-023 A pop when empty SHALL drive no strobe, leave depth unchanged, set unf and hold rd_data.
REQ-024 DONE: SHALL pulse ack for the granted requester for one cycle, with rd_valid=1 only for a legal pop and err=1 only for a rejected operation.
REQ-025 After DONE, requester state SHALL be re-sampled in IDLE; a req still high there is treated as a new operation.
REQ-026 full SHALL equal (depth==DEPTH) and empty SHALL equal (depth==0), both combinational from depth.
REQ-027 If err_clr coincides with a new error, the set SHALL win; otherwise err_clr clears ovf and unf on the next edge.
REQ-028 stk_in SHALL hold the last pushed value outside ISSUE; rd_data SHALL hold its value until the next legal pop.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, depth=0, all acks, strobes, rd_valid, err, ovf and unf=0, rd_data and stk_in=0, and the round-robin pointer to favour A.
REQ-030 Reset mid-operation SHALL abort it without an ack; stack contents are then don't-care because depth=0.

Verification
REQ-031 Reset, then an A push of 0x1A5 -> stk_push high in cycle 2 only; a_ack, depth=1 and empty=0 in cycle 3.
REQ-032 Push 0x011, push 0x022, then pop -> rd_data=0x022 with rd_valid and ack; depth=1; next pop -> 0x011, empty=1.
REQ-033 Two pushes, then a third push -> no strobe, a_ack with err=1, ovf=1, depth stays 2; err_clr -> ovf=0.
REQ-034 Pop with the stack empty -> no stk_pop, ack with err=1, unf=1, rd_data unchanged.
REQ-035 a_req and b_req held high continuously -> grants alternate A,B,A,B with one ack per 3 cycles; never two acks in the same cycle.
REQ-036 rst_n low during ISSUE of a push -> no ack, depth=0, all strobes low immediately.
